// File: rtl/compare_scheduler_pkg.sv
// Shared definitions for the compare_scheduler block.
// Contents:
//   state_e   - scheduler FSM state encoding (IDLE, SCAN, DONE)
//   idx_width - width needed to index n items, never less than 1
package compare_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/compare_scheduler_lane_min.sv
// lane_min_select: combinational reduction of LANES (value, valid) pairs to the
// smallest valid value, its lane offset, and whether any lane was valid.
// Equal values keep the lowest lane offset.
// Ports:
//   lane_values - LANES packed values, lane l at [(l+1)*DATA_WIDTH-1 : l*DATA_WIDTH]
//   lane_valids - per-lane valid
//   min_value   - smallest valid value (0 when none valid)
//   min_lane    - lane offset of min_value (0 when none valid)
//   any_valid   - at least one lane valid
module lane_min_select
  import compare_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 2,
  localparam int unsigned LANE_W    = idx_width(LANES)
) (
  input  logic [DATA_WIDTH*LANES-1:0] lane_values,
  input  logic [LANES-1:0]            lane_valids,
  output logic [DATA_WIDTH-1:0]       min_value,
  output logic [LANE_W-1:0]           min_lane,
  output logic                        any_valid
);

  always_comb begin
    min_value = '0;
    min_lane  = '0;
    any_valid = 1'b0;
    // Strict less-than keeps the earliest lane on ties.
    for (int unsigned l = 0; l < LANES; l++) begin
      if (lane_valids[l] &&
          (!any_valid || lane_values[l*DATA_WIDTH +: DATA_WIDTH] < min_value)) begin
        min_value = lane_values[l*DATA_WIDTH +: DATA_WIDTH];
        min_lane  = LANE_W'(l);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/compare_scheduler.sv
// compare_scheduler: elects the unsigned minimum of the valid channels of a
// snapshot, LANES channels per cycle, falling back to default_value when no
// channel is valid or the best channel is not strictly below the default.
// Optional feature: define COMPARE_SCHEDULER_ABORT_EN to add the abort input,
// which returns SCAN/DONE to IDLE without a result.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start               - begin an election (accepted in IDLE, or DONE with result_ready)
//   default_value       - fallback value, captured on acceptance
//   values, valids      - per-channel values and valids, captured on acceptance
//   abort               - (COMPARE_SCHEDULER_ABORT_EN only) drop the election in flight
//   result_ready        - consumer ready for the result
//   busy                - FSM not in IDLE
//   result, result_index, result_is_default, result_valid - election outcome
module compare_scheduler
  import compare_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned CHANNEL_COUNT = 6,
  parameter int unsigned LANES         = 2,
  localparam int unsigned IDX_W        = idx_width(CHANNEL_COUNT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [DATA_WIDTH-1:0]         default_value,
  input  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] values,
  input  logic [CHANNEL_COUNT-1:0]      valids,
`ifdef COMPARE_SCHEDULER_ABORT_EN
  input  logic                          abort,
`endif
  input  logic                          result_ready,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         result,
  output logic [IDX_W-1:0]              result_index,
  output logic                          result_is_default,
  output logic                          result_valid
);

  // Cursor must reach the first index past the last scan group.
  localparam int unsigned CUR_W    = idx_width(CHANNEL_COUNT + LANES);
  localparam int unsigned LANE_W   = idx_width(LANES);
  localparam logic [CUR_W-1:0] CUR_END  = CUR_W'(CHANNEL_COUNT);
  localparam logic [CUR_W-1:0] CUR_STEP = CUR_W'(LANES);

  state_e                             state_q, state_d;
  logic [CUR_W-1:0]                   cursor_q, cursor_d;
  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] snap_values_q, snap_values_d;
  logic [CHANNEL_COUNT-1:0]           snap_valids_q, snap_valids_d;
  logic [DATA_WIDTH-1:0]              snap_default_q, snap_default_d;
  logic [DATA_WIDTH-1:0]              best_q, best_d;
  logic [IDX_W-1:0]                   best_idx_q, best_idx_d;
  logic                               best_found_q, best_found_d;
  logic [DATA_WIDTH-1:0]              result_q, result_d;
  logic [IDX_W-1:0]                   result_index_q, result_index_d;
  logic                               result_is_default_q, result_is_default_d;

  logic [DATA_WIDTH*LANES-1:0]        lane_values;
  logic [LANES-1:0]                   lane_valids;
  logic [DATA_WIDTH-1:0]              lane_min;
  logic [LANE_W-1:0]                  lane_min_idx;
  logic                               lane_any;
  logic [IDX_W-1:0]                   cand_idx;
  logic                               cand_better;
  logic                               accept;
  logic                               abort_req;

`ifdef COMPARE_SCHEDULER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Route snapshot channels cursor..cursor+LANES-1 onto the lanes; lanes past
  // the last channel match no channel and stay invalid.
  always_comb begin
    lane_values = '0;
    lane_valids = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned c = 0; c < CHANNEL_COUNT; c++) begin
        if (CUR_W'(c) == cursor_q + CUR_W'(l)) begin
          lane_values[l*DATA_WIDTH +: DATA_WIDTH] = snap_values_q[c*DATA_WIDTH +: DATA_WIDTH];
          lane_valids[l]                          = snap_valids_q[c];
        end
      end
    end
  end

  lane_min_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_lane_min (
    .lane_values (lane_values),
    .lane_valids (lane_valids),
    .min_value   (lane_min),
    .min_lane    (lane_min_idx),
    .any_valid   (lane_any)
  );

  assign cand_idx    = IDX_W'(cursor_q + CUR_W'(lane_min_idx));
  // Later groups only hold higher indices, so strict less-than preserves the
  // lower index on ties across groups.
  assign cand_better = lane_any && (!best_found_q || lane_min < best_q);

  always_comb begin
    state_d             = state_q;
    cursor_d            = cursor_q;
    snap_values_d       = snap_values_q;
    snap_valids_d       = snap_valids_q;
    snap_default_d      = snap_default_q;
    best_d              = best_q;
    best_idx_d          = best_idx_q;
    best_found_d        = best_found_q;
    result_d            = result_q;
    result_index_d      = result_index_q;
    result_is_default_d = result_is_default_q;
    accept              = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) accept = 1'b1;
      end
      StScan: begin
        // One extra SCAN cycle past the last group resolves the result.
        if (cursor_q >= CUR_END) begin
          state_d = StDone;
          if (!best_found_q || best_q >= snap_default_q) begin
            result_d            = snap_default_q;
            result_index_d      = '0;
            result_is_default_d = 1'b1;
          end else begin
            result_d            = best_q;
            result_index_d      = best_idx_q;
            result_is_default_d = 1'b0;
          end
        end else begin
          cursor_d = cursor_q + CUR_STEP;
          if (cand_better) begin
            best_d       = lane_min;
            best_idx_d   = cand_idx;
            best_found_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (result_ready) begin
          if (start) accept = 1'b1;
          else       state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort_req && state_q != StIdle) begin
      accept  = 1'b0;
      state_d = StIdle;
    end

    if (accept) begin
      state_d        = StScan;
      snap_values_d  = values;
      snap_valids_d  = valids;
      snap_default_d = default_value;
      best_d         = '0;
      best_idx_d     = '0;
      best_found_d   = 1'b0;
      cursor_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= StIdle;
      cursor_q            <= '0;
      snap_values_q       <= '0;
      snap_valids_q       <= '0;
      snap_default_q      <= '0;
      best_q              <= '0;
      best_idx_q          <= '0;
      best_found_q        <= 1'b0;
      result_q            <= '0;
      result_index_q      <= '0;
      result_is_default_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      cursor_q            <= cursor_d;
      snap_values_q       <= snap_values_d;
      snap_valids_q       <= snap_valids_d;
      snap_default_q      <= snap_default_d;
      best_q              <= best_d;
      best_idx_q          <= best_idx_d;
      best_found_q        <= best_found_d;
      result_q            <= result_d;
      result_index_q      <= result_index_d;
      result_is_default_q <= result_is_default_d;
    end
  end

  assign busy              = (state_q != StIdle);
  assign result_valid      = (state_q == StDone);
  assign result            = result_q;
  assign result_index      = result_index_q;
  assign result_is_default = result_is_default_q;

endmodule

// File: tb/tb_compare_scheduler.sv
// Self-checking bench for compare_scheduler (DATA_WIDTH=8, CHANNEL_COUNT=6, LANES=2).
module tb_compare_scheduler;

  localparam int DW = 8;
  localparam int CH = 6;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [DW-1:0]  default_value;
  logic [DW*CH-1:0] values;
  logic [CH-1:0]  valids;
  logic           result_ready;
  logic           busy;
  logic [DW-1:0]  result;
  logic [IW-1:0]  result_index;
  logic           result_is_default;
  logic           result_valid;

  always #5 clk = ~clk;

  compare_scheduler #(
    .DATA_WIDTH    (DW),
    .CHANNEL_COUNT (CH),
    .LANES         (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .default_value     (default_value),
    .values            (values),
    .valids            (valids),
    .result_ready      (result_ready),
    .busy              (busy),
    .result            (result),
    .result_index      (result_index),
    .result_is_default (result_is_default),
    .result_valid      (result_valid)
  );

  typedef struct {
    logic [DW*CH-1:0] vals;
    logic [CH-1:0]    vld;
    logic [DW-1:0]    dflt;
    logic [DW-1:0]    exp_res;
    logic [IW-1:0]    exp_idx;
    logic             exp_def;
  } vec_t;

  typedef struct {
    logic [DW-1:0] res;
    logic [IW-1:0] idx;
    logic          def;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*CH-1:0] pk(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5);
    return {8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic vec_t mk(input logic [DW*CH-1:0] v, input logic [CH-1:0] m,
                              input int d, input int er, input int ei, input bit ed);
    vec_t t;
    t.vals = v; t.vld = m; t.dflt = 8'(d);
    t.exp_res = 8'(er); t.exp_idx = 3'(ei); t.exp_def = ed;
    return t;
  endfunction

  function automatic exp_t tbl_exp(input vec_t t);
    exp_t e;
    e.res = t.exp_res; e.idx = t.exp_idx; e.def = t.exp_def;
    return e;
  endfunction

  // Reference election over the whole snapshot at once.
  function automatic exp_t model(input logic [DW*CH-1:0] v, input logic [CH-1:0] m,
                                 input logic [DW-1:0] d);
    exp_t e;
    bit found = 0;
    logic [DW-1:0] b = '0;
    int bi = 0;
    for (int i = 0; i < CH; i++) begin
      if (m[i] && (!found || v[i*DW +: DW] < b)) begin
        found = 1; b = v[i*DW +: DW]; bi = i;
      end
    end
    if (!found || b >= d) begin
      e.res = d; e.idx = '0; e.def = 1'b1;
    end else begin
      e.res = b; e.idx = 3'(bi); e.def = 1'b0;
    end
    return e;
  endfunction

  // Start from IDLE; inputs are scrambled right after acceptance.
  task automatic launch(input logic [DW*CH-1:0] v, input logic [CH-1:0] m,
                        input logic [DW-1:0] d, input exp_t e, input bit push);
    values = v; valids = m; default_value = d; start = 1'b1;
    tick();
    start = 1'b0;
    if (push) sb.push_back(e);
    values        = 48'({$urandom(), $urandom()});
    valids        = 6'($urandom());
    default_value = 8'($urandom());
  endtask

  task automatic collect(input bit chk_lat);
    int n = 0;
    exp_t e;
    while (!result_valid && n < 12) begin
      tick();
      n++;
    end
    if (!result_valid) begin
      check("result_timeout", 0, 1);
      if (sb.size() != 0) e = sb.pop_front();
      return;
    end
    if (chk_lat) check("latency", n, 4);
    if (sb.size() == 0) begin
      check("unexpected_result", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("result", result, e.res);
    check("result_index", result_index, e.idx);
    check("result_is_default", result_is_default, e.def);
  endtask

  initial begin
    bit seen;
    exp_t e;
    logic [DW*CH-1:0] rv;
    logic [CH-1:0] rm;
    logic [DW-1:0] rd;

    tbl[0] = mk(pk(30, 12, 7, 90, 7, 40),        6'h3F,      100, 7,   2, 0);
    tbl[1] = mk(pk(30, 12, 7, 90, 7, 40),        6'h00,      55,  55,  0, 1);
    tbl[2] = mk(pk(1, 1, 1, 1, 1, 55),           6'b100000,  55,  55,  0, 1);
    tbl[3] = mk(pk(200, 201, 202, 203, 204, 250), 6'h3F,     255, 200, 0, 0);
    tbl[4] = mk(pk(0, 0, 0, 0, 0, 3),            6'b100000,  10,  3,   5, 0);
    tbl[5] = mk(pk(128, 127, 200, 200, 200, 200), 6'h3F,     255, 127, 1, 0);
    tbl[6] = mk(pk(50, 9, 50, 9, 9, 50),         6'h3F,      60,  9,   1, 0);
    tbl[7] = mk(pk(60, 60, 60, 60, 60, 60),      6'h3F,      55,  55,  0, 1);
    tbl[8] = mk(pk(60, 60, 60, 54, 60, 60),      6'h3F,      55,  54,  3, 0);
    tbl[9] = mk(pk(5, 60, 60, 60, 60, 60),       6'b111110,  55,  55,  0, 1);

    reset = 1'b1; start = 1'b0; result_ready = 1'b1;
    values = '0; valids = '0; default_value = '0;
    tick();
    tick();
    check("reset_busy", busy, 0);
    check("reset_result_valid", result_valid, 0);
    check("reset_result", result, 0);
    check("reset_result_index", result_index, 0);
    check("reset_is_default", result_is_default, 0);
    reset = 1'b0;
    tick();

    // Table vectors, ready held high.
    for (int i = 0; i < 10; i++) begin
      launch(tbl[i].vals, tbl[i].vld, tbl[i].dflt, tbl_exp(tbl[i]), 1'b1);
      collect(1'b1);
      tick();
      check("valid_drop", result_valid, 0);
    end

    // Random elections with small values to provoke ties.
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < CH; c++) rv[c*DW +: DW] = 8'($urandom_range(0, 15));
      rm = 6'($urandom());
      rd = 8'($urandom_range(0, 16));
      launch(rv, rm, rd, model(rv, rm, rd), 1'b1);
      collect(1'b1);
      tick();
    end

    // Hold with ready low; ignored starts; then back-to-back acceptance.
    result_ready = 1'b0;
    launch(tbl[0].vals, tbl[0].vld, tbl[0].dflt, tbl_exp(tbl[0]), 1'b1);
    collect(1'b1);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; values = pk(1, 1, 1, 1, 1, 1); valids = 6'h3F; default_value = 8'd200;
      tick();
      check("hold_valid", result_valid, 1);
      check("hold_result", result, 7);
      check("hold_index", result_index, 2);
      check("hold_is_default", result_is_default, 0);
    end
    result_ready = 1'b1; start = 1'b1;
    values = tbl[3].vals; valids = tbl[3].vld; default_value = tbl[3].dflt;
    tick();
    start = 1'b0;
    sb.push_back(tbl_exp(tbl[3]));
    values = '0; valids = 6'h3F; default_value = '0;
    check("b2b_busy", busy, 1);
    check("b2b_valid_low", result_valid, 0);
    collect(1'b1);
    tick();

    // start during SCAN is neither accepted nor queued.
    launch(tbl[6].vals, tbl[6].vld, tbl[6].dflt, tbl_exp(tbl[6]), 1'b1);
    start = 1'b1; values = tbl[3].vals; valids = tbl[3].vld; default_value = tbl[3].dflt;
    tick();
    tick();
    start = 1'b0;
    collect(1'b0);
    tick();
    check("scan_start_not_queued", busy, 0);

    // Reset during the second SCAN cycle discards the election.
    launch(tbl[0].vals, tbl[0].vld, tbl[0].dflt, tbl_exp(tbl[0]), 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_valid", result_valid, 0);
    check("midreset_result", result, 0);
    check("midreset_index", result_index, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= result_valid;
    end
    check("midreset_no_pulse", seen, 0);

    // Recovery after reset.
    launch(tbl[8].vals, tbl[8].vld, tbl[8].dflt, tbl_exp(tbl[8]), 1'b1);
    collect(1'b1);
    tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
